ecc_stream_decoder: RTL and testbench

Receive-side AXI-Stream SECDED decoder for the 2D-ECC IP core. It accepts 25-bit 2D-parity codewords, for example from memory or a link that the encode path wrote, and corrects any single-bit error. Double-bit errors are detected and flagged. Corrected 16-bit data goes out on an AXI-Stream master. The block also keeps saturating error counters for the SoC reliability monitor. It is the reader counterpart to the encode-side stream wrapper.

---
 rtl/ecc_stream_decoder_if.sv | 21 ++
 rtl/ecc_stream_decoder.sv | 154 +++++++++++++++
 tb/tb_ecc_stream_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_stream_decoder_if.sv
// Stream bundle for ecc_stream_decoder: 25-bit codeword sink side and 16-bit decoded-data source side.
// A beat transfers on a rising clk edge where valid and ready are both high; once raised, valid and its payload hold until that edge.
interface ecc_stream_decoder_if;
    logic [24:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
    );
endinterface

// File: rtl/ecc_stream_decoder.sv
// Two-stage SECDED decoder for 2D-parity codewords with saturating error counters.
// Define ECC_DROP_UNCORRECTABLE_EN to count/flag but never emit uncorrectable words.
module ecc_stream_decoder #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ecc_stream_decoder_if.slave  axis,
    input  logic                 clear_counts,
    output logic                 single_error_flag,
    output logic                 double_error_flag,
    output logic [CNT_W-1:0]     single_count,
    output logic [CNT_W-1:0]     double_count
);

    logic             rdy_en_q, rdy_en_d;
    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_data_q, s1_data_d;
    logic [3:0]       s1_rs_q, s1_rs_d;
    logic [3:0]       s1_cs_q, s1_cs_d;
    logic             s1_p_q, s1_p_d;
    logic             s2_valid_q, s2_valid_d;
    logic [15:0]      s2_data_q, s2_data_d;
    logic [1:0]       s2_user_q, s2_user_d;
    logic             sflag_q, sflag_d;
    logic             dflag_q, dflag_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    logic        s2_adv, s1_adv, s_ready, s_fire, s1_move;
    logic [3:0]  rp_calc, cp_calc;
    logic        rs_zero, cs_zero, rs_one, cs_one;
    logic        is_clean, is_corr, is_uncorr, flip_en, keep_word;
    logic [15:0] flip_mask, fixed_data;

    always_comb begin
        s2_adv  = !s2_valid_q || axis.m_axis_tready;
        s1_adv  = !s1_valid_q || s2_adv;
        s_ready = rdy_en_q && s1_adv;
        s_fire  = axis.s_axis_tvalid && s_ready;
        s1_move = s1_valid_q && s2_adv;

        rp_calc[0] = ^axis.s_axis_tdata[3:0];
        rp_calc[1] = ^axis.s_axis_tdata[7:4];
        rp_calc[2] = ^axis.s_axis_tdata[11:8];
        rp_calc[3] = ^axis.s_axis_tdata[15:12];
        cp_calc    = axis.s_axis_tdata[3:0] ^ axis.s_axis_tdata[7:4]
                   ^ axis.s_axis_tdata[11:8] ^ axis.s_axis_tdata[15:12];

        rs_zero   = (s1_rs_q == 4'd0);
        cs_zero   = (s1_cs_q == 4'd0);
        rs_one    = !rs_zero && ((s1_rs_q & (s1_rs_q - 4'd1)) == 4'd0);
        cs_one    = !cs_zero && ((s1_cs_q & (s1_cs_q - 4'd1)) == 4'd0);
        is_clean  = !s1_p_q && rs_zero && cs_zero;
        // Any syndrome a lone flipped bit can produce is correctable; row+col pins a data bit.
        is_corr   = s1_p_q && ((rs_one || rs_zero) && (cs_one || cs_zero));
        is_uncorr = !is_clean && !is_corr;
        flip_en   = s1_p_q && rs_one && cs_one;

        flip_mask  = {{4{s1_rs_q[3]}} & s1_cs_q, {4{s1_rs_q[2]}} & s1_cs_q,
                      {4{s1_rs_q[1]}} & s1_cs_q, {4{s1_rs_q[0]}} & s1_cs_q};
        fixed_data = flip_en ? (s1_data_q ^ flip_mask) : s1_data_q;
`ifdef ECC_DROP_UNCORRECTABLE_EN
        keep_word  = !is_uncorr;
`else
        keep_word  = 1'b1;
`endif
    end

    always_comb begin
        rdy_en_d   = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_rs_d    = s1_rs_q;
        s1_cs_d    = s1_cs_q;
        s1_p_d     = s1_p_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_user_d  = s2_user_q;
        sflag_d    = s1_move && is_corr;
        dflag_d    = s1_move && is_uncorr;
        scnt_d     = scnt_q;
        dcnt_d     = dcnt_q;

        if (s1_adv) begin
            s1_valid_d = s_fire;
            if (s_fire) begin
                s1_data_d = axis.s_axis_tdata[15:0];
                s1_rs_d   = rp_calc ^ axis.s_axis_tdata[19:16];
                s1_cs_d   = cp_calc ^ axis.s_axis_tdata[23:20];
                s1_p_d    = ^axis.s_axis_tdata;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q && keep_word;
            if (s1_valid_q) begin
                s2_data_d = fixed_data;
                s2_user_d = {is_uncorr && keep_word, is_corr};
            end
        end

        // Clear has priority over a coincident increment.
        if (clear_counts) begin
            scnt_d = '0;
            dcnt_d = '0;
        end else begin
            if (sflag_d && (scnt_q != {CNT_W{1'b1}})) scnt_d = scnt_q + CNT_W'(1);
            if (dflag_d && (dcnt_q != {CNT_W{1'b1}})) dcnt_d = dcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_rs_q    <= '0;
            s1_cs_q    <= '0;
            s1_p_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_user_q  <= '0;
            sflag_q    <= 1'b0;
            dflag_q    <= 1'b0;
            scnt_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            rdy_en_q   <= rdy_en_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_rs_q    <= s1_rs_d;
            s1_cs_q    <= s1_cs_d;
            s1_p_q     <= s1_p_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_user_q  <= s2_user_d;
            sflag_q    <= sflag_d;
            dflag_q    <= dflag_d;
            scnt_q     <= scnt_d;
            dcnt_q     <= dcnt_d;
        end
    end

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tvalid = s2_valid_q;
    assign axis.m_axis_tdata  = s2_data_q;
    assign axis.m_axis_tuser  = s2_user_q;
    assign single_error_flag  = sflag_q;
    assign double_error_flag  = dflag_q;
    assign single_count       = scnt_q;
    assign double_count       = dcnt_q;

endmodule

// File: tb/tb_ecc_stream_decoder.sv
// Randomized bench for ecc_stream_decoder against a search-based SECDED reference model.
module tb_ecc_stream_decoder;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear_counts;
    logic             single_error_flag, double_error_flag;
    logic [CNT_W-1:0] single_count, double_count;

    ecc_stream_decoder_if bus();

    ecc_stream_decoder #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .axis              (bus.slave),
        .clear_counts      (clear_counts),
        .single_error_flag (single_error_flag),
        .double_error_flag (double_error_flag),
        .single_count      (single_count),
        .double_count      (double_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [17:0] exp_q[$];
    int          sc_m = 0, dc_m = 0;
    int          sflag_m = 0, dflag_m = 0;
    int          sflag_seen = 0, dflag_seen = 0;
    int          n_beats = 0;
    int          ready_pct = 100;
    bit          hold_low = 1'b0;
    bit          saw_block = 1'b0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_beat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [24:0] encode(input logic [15:0] d);
        logic [24:0] cw;
        cw = {9'd0, d};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                cw[16 + r] = cw[16 + r] ^ d[4 * r + c];
                cw[20 + c] = cw[20 + c] ^ d[4 * r + c];
            end
        cw[24] = ^cw[23:0];
        return cw;
    endfunction

    // Valid codeword -> clean; one flip away from a valid codeword -> corrected; else uncorrectable.
    function automatic logic [17:0] ref_decode(input logic [24:0] cw, output int cls);
        logic [24:0] t;
        if (encode(cw[15:0]) == cw) begin
            cls = 0;
            return {2'b00, cw[15:0]};
        end
        for (int k = 0; k < 25; k++) begin
            t = cw ^ (25'd1 << k);
            if (encode(t[15:0]) == t) begin
                cls = 1;
                return {2'b01, t[15:0]};
            end
        end
        cls = 2;
        return {2'b10, cw[15:0]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    function automatic logic [24:0] mk_word(input int kind);
        logic [24:0] cw;
        int a, b;
        cw = encode(16'($urandom));
        case (kind)
            1: cw = cw ^ (25'd1 << $urandom_range(0, 15));
            2: cw = cw ^ (25'd1 << $urandom_range(16, 24));
            3: begin
                a  = $urandom_range(0, 24);
                b  = (a + $urandom_range(1, 24)) % 25;
                cw = cw ^ (25'd1 << a) ^ (25'd1 << b);
            end
            4: cw = 25'($urandom);
            default: ;
        endcase
        return cw;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [17:0] res;
        logic [17:0] beat;
        int          cls;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            beat = {bus.m_axis_tuser, bus.m_axis_tdata};
            if (prev_stall) begin
                check("hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
                check("hold_beat", 32'(beat), 32'(prev_beat));
            end
            if (bus.s_axis_tvalid && !bus.s_axis_tready) saw_block = 1'b1;
            if (single_error_flag) sflag_seen++;
            if (double_error_flag) dflag_seen++;
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                res = ref_decode(bus.s_axis_tdata, cls);
                if (cls == 1) begin sc_m = sat_inc(sc_m); sflag_m++; end
                if (cls == 2) begin dc_m = sat_inc(dc_m); dflag_m++; end
`ifdef ECC_DROP_UNCORRECTABLE_EN
                if (cls != 2) exp_q.push_back(res);
`else
                exp_q.push_back(res);
`endif
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                n_beats++;
                if (exp_q.size() == 0) check("spurious_beat", 32'd1, 32'd0);
                else check("beat", 32'(beat), 32'(exp_q.pop_front()));
            end
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_beat  = beat;
        end
    end

    // ---------------- downstream ready generator ----------------
    initial begin
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) bus.m_axis_tready = 1'b0;
            else bus.m_axis_tready = ($urandom_range(1, 100) <= ready_pct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [24:0] cw);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = cw;
        do begin
            @(negedge clk);
            ok = bus.s_axis_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 300);
        bus.s_axis_tvalid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_counts = 1'b1;
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
        sc_m = 0;
        dc_m = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_axis_tready), 32'd0);
        check({tag, "_m_valid"}, 32'(bus.m_axis_tvalid), 32'd0);
        check({tag, "_m_data"}, 32'(bus.m_axis_tdata), 32'd0);
        check({tag, "_m_user"}, 32'(bus.m_axis_tuser), 32'd0);
        check({tag, "_sflag"}, 32'(single_error_flag), 32'd0);
        check({tag, "_dflag"}, 32'(double_error_flag), 32'd0);
        check({tag, "_scnt"}, 32'(single_count), 32'd0);
        check({tag, "_dcnt"}, 32'(double_count), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_scnt"}, 32'(single_count), 32'(sc_m));
        check({tag, "_dcnt"}, 32'(double_count), 32'(dc_m));
        check({tag, "_sflags"}, 32'(sflag_seen), 32'(sflag_m));
        check({tag, "_dflags"}, 32'(dflag_seen), 32'(dflag_m));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [24:0] base;
        int          b0;
        reset_n           = 1'b0;
        clear_counts      = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk);
        #1;

        // Clean word and two-cycle latency
        base = encode(16'hA5C3);
        send(base);
        @(negedge clk);
        check("lat_stage1", 32'(bus.m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("lat_stage2", 32'(bus.m_axis_tvalid), 32'd1);
        check("clean_data", 32'(bus.m_axis_tdata), 32'hA5C3);
        check("clean_user", 32'(bus.m_axis_tuser), 32'd0);
        drain();
        check("clean_scnt", 32'(single_count), 32'd0);
        check("clean_dcnt", 32'(double_count), 32'd0);

        // Single data-bit error
        send(base ^ (25'd1 << 5));
        drain();
        check("single_scnt", 32'(single_count), 32'd1);
        check("single_pulses", 32'(sflag_seen), 32'd1);

        // Parity-bit errors
        pulse_clear();
        send(base ^ (25'd1 << 24));
        send(base ^ (25'd1 << 18));
        drain();
        check("parity_scnt", 32'(single_count), 32'd2);

        // Double error
        send(base ^ (25'd1 << 3) ^ (25'd1 << 12));
        drain();
        check("double_dcnt", 32'(double_count), 32'd1);
        check("double_pulses", 32'(dflag_seen), 32'd1);
        check_counts("directed");

        // Backpressure: 8 back-to-back words, downstream stalled for 5 cycles
        saw_block = 1'b0;
        b0 = n_beats;
        fork
            for (int i = 0; i < 8; i++) send(mk_word($urandom_range(0, 2)));
            begin
                repeat (2) @(posedge clk);
                hold_low = 1'b1;
                repeat (5) @(posedge clk);
                hold_low = 1'b0;
            end
        join
        drain();
        check("bp_blocked", 32'(saw_block), 32'd1);
        check("bp_beats", 32'(n_beats - b0), 32'd8);

        // Randomized traffic with random downstream readiness
        pulse_clear();
        ready_pct = 65;
        for (int i = 0; i < 300; i++) begin
            send(mk_word($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        ready_pct = 100;
        drain();
        check_counts("random");

        // Saturation, then clear coinciding with an increment
        pulse_clear();
        for (int i = 0; i < 5; i++) send(mk_word(1));
        drain();
        check("sat_scnt", 32'(single_count), 32'd3);
        send(mk_word(1));
        pulse_clear();
        drain();
        check("clear_wins_scnt", 32'(single_count), 32'd0);
        check_counts("sat");

        // Reset with words in flight (clean words so no flags are pending)
        hold_low = 1'b1;
        send(encode(16'h1234));
        send(encode(16'hBEEF));
        @(negedge clk);
        check("full_ready_low", 32'(bus.s_axis_tready), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        exp_q.delete();
        sc_m = 0;
        dc_m = 0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        hold_low = 1'b0;
        b0 = n_beats;
        repeat (6) @(negedge clk);
        check("no_stale_beat", 32'(n_beats - b0), 32'd0);
        check("post_reset_scnt", 32'(single_count), 32'd0);
        check("post_reset_ready", 32'(bus.s_axis_tready), 32'd1);

        send(encode(16'h0F0F));
        drain();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
